// File: rtl/bank_req_arbiter_pkg.sv
// Shared sizes and request record for the bank request arbiter.
// REG_SIZE is the bank word/address width; BANK_ARB_LAT is the accept-to-response delay in cycles.
package bank_req_arbiter_pkg;
  localparam int REG_SIZE      = 8;
  localparam int BANK_ARB_NREQ = 4;
  localparam int BANK_ARB_LAT  = 2;

  typedef logic [REG_SIZE-1:0] reg_t;

  typedef struct packed {
    logic we;
    reg_t addr;
    reg_t data;
  } bank_req_t;
endpackage

// File: rtl/bank_req_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set req bit, scanning upward from ptr with wraparound.
module rr_pick
  import bank_req_arbiter_pkg::*;
#(
  parameter  int N    = BANK_ARB_NREQ,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);
  always_comb begin
    int idx;
    idx        = 0;
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_id          = ID_W'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bank_req_arbiter.sv
// Round-robin front end for one memory bank, with a two-stage response return path.
// Optional BANK_ARB_STALL_CNT_EN adds saturating per-core stall counters on stall_cnt.
module bank_req_arbiter
  import bank_req_arbiter_pkg::*;
#(
  parameter  int BANK_ID = 0,
  parameter  int N_REQ   = BANK_ARB_NREQ,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*REG_SIZE-1:0] req_addr,
  input  logic [N_REQ*REG_SIZE-1:0] req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [REG_SIZE-1:0]       rsp_data,
  output logic [REG_SIZE-1:0]       bank_addr,
  output logic [REG_SIZE-1:0]       bank_data_in,
  output logic                      bank_read_enable,
  output logic                      bank_write_enable,
  input  logic [REG_SIZE-1:0]       bank_data_out
`ifdef BANK_ARB_STALL_CNT_EN
  ,
  output logic [N_REQ*16-1:0]       stall_cnt
`endif
);
  localparam int LAT = BANK_ARB_LAT;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [N_REQ-1:0] gnt_onehot;
  logic             any;
  logic             acc;
  bank_req_t        sel;

  logic [LAT:1]           vld_pipe;
  logic [LAT:1][ID_W-1:0] id_pipe;
  logic [LAT:1]           we_pipe;

  rr_pick #(.N(N_REQ)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .any        (any)
  );

  assign acc       = any & ~reset;
  assign req_ready = reset ? '0 : gnt_onehot;

  always_comb begin
    sel.we   = req_we[gnt_id];
    sel.addr = req_addr[int'(gnt_id)*REG_SIZE +: REG_SIZE];
    sel.data = req_wdata[int'(gnt_id)*REG_SIZE +: REG_SIZE];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr            <= '0;
      bank_addr         <= '0;
      bank_data_in      <= '0;
      bank_read_enable  <= 1'b0;
      bank_write_enable <= 1'b0;
      vld_pipe          <= '0;
      id_pipe           <= '0;
      we_pipe           <= '0;
    end else begin
      vld_pipe[1] <= acc;
      id_pipe[1]  <= gnt_id;
      we_pipe[1]  <= sel.we;
      for (int s = 2; s <= LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
        we_pipe[s]  <= we_pipe[s-1];
      end
      if (acc) begin
        bank_addr         <= sel.addr;
        bank_data_in      <= sel.data;
        bank_write_enable <= sel.we;
        bank_read_enable  <= ~sel.we;
        rr_ptr            <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
      end else begin
        bank_write_enable <= 1'b0;
        bank_read_enable  <= 1'b0;
      end
    end
  end

  // Writes are acknowledged with zero data; the bank's data_out is only forwarded for reads.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (!reset && vld_pipe[LAT]) begin
      rsp_valid[id_pipe[LAT]] = 1'b1;
      if (!we_pipe[LAT]) rsp_data = bank_data_out;
    end
  end

`ifdef BANK_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && stall_cnt[i*16 +: 16] != 16'hFFFF)
          stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_bank_req_arbiter.sv
// Directed bench for bank_req_arbiter with a behavioural bank and a queue-based reference model.
module tb_bank_req_arbiter;
  import bank_req_arbiter_pkg::*;
  localparam int N = 4;
  localparam int W = REG_SIZE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_we, req_ready, rsp_valid;
  logic [N*W-1:0] req_addr, req_wdata;
  logic [W-1:0]   rsp_data, bank_addr, bank_data_in, bank_data_out;
  logic           bank_read_enable, bank_write_enable;
`ifdef BANK_ARB_STALL_CNT_EN
  logic [N*16-1:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  bank_req_arbiter #(.BANK_ID(0), .N_REQ(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .bank_addr         (bank_addr),
    .bank_data_in      (bank_data_in),
    .bank_read_enable  (bank_read_enable),
    .bank_write_enable (bank_write_enable),
    .bank_data_out     (bank_data_out)
`ifdef BANK_ARB_STALL_CNT_EN
    ,
    .stall_cnt         (stall_cnt)
`endif
  );

  // Bank: registered read, ignores everything while reset is high.
  logic [W-1:0] mem [256];
  always @(posedge clk) begin
    if (reset) bank_data_out <= '0;
    else begin
      if (bank_write_enable) mem[bank_addr] <= bank_data_in;
      if (bank_read_enable)  bank_data_out  <= mem[bank_addr];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // Reference model: accepted requests are queued with an age; at age 2 the bank has acted
  // and the response is visible for one cycle.
  typedef struct {
    int           id;
    bit           we;
    logic [W-1:0] a;
    logic [W-1:0] d;
    int           age;
  } ent_t;

  ent_t         q[$];
  int           m_rr = 0;
  logic [W-1:0] m_mem [256];

  always @(posedge clk) begin
    ent_t e;
    int   w;
    if (reset) begin
      m_rr = 0;
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].age == 2) void'(q.pop_front());
      foreach (q[k]) begin
        q[k].age++;
        if (q[k].age == 2) begin
          if (q[k].we) m_mem[q[k].a] = q[k].d;
          else         q[k].d = m_mem[q[k].a];
        end
      end
      w = pick(req_valid, m_rr);
      if (w >= 0) begin
        e.id  = w;
        e.we  = req_we[w];
        e.a   = req_addr[w*W +: W];
        e.d   = req_wdata[w*W +: W];
        e.age = 1;
        q.push_back(e);
        m_rr = (w + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] er, ev;
    logic [W-1:0] ed;
    logic         ere, ewe;
    int           w;
    er = '0; ev = '0; ed = '0; ere = 1'b0; ewe = 1'b0;
    w = pick(req_valid, m_rr);
    if (!reset && w >= 0) er[w] = 1'b1;
    if (!reset && q.size() > 0 && q[0].age == 2) begin
      ev[q[0].id] = 1'b1;
      if (!q[0].we) ed = q[0].d;
    end
    if (q.size() > 0 && q[q.size()-1].age == 1) begin
      ewe = q[q.size()-1].we;
      ere = !q[q.size()-1].we;
      chk("m_bank_addr", 32'(bank_addr), 32'(q[q.size()-1].a));
    end
    chk("m_req_ready", 32'(req_ready), 32'(er));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("m_rsp_data",  32'(rsp_data),  32'(ed));
    chk("m_bank_we",   32'(bank_write_enable), 32'(ewe));
    chk("m_bank_re",   32'(bank_read_enable),  32'(ere));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic rq(input int i, input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
    req_valid[i]       = 1'b1;
    req_we[i]          = we;
    req_addr[i*W +: W] = a;
    req_wdata[i*W +: W] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    // reset state, with requests present
    reset = 1'b1;
    for (int i = 0; i < N; i++) rq(i, 1'b0, 8'h00, 8'h00);
    cyc();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_bank", 32'({bank_addr, bank_data_in, bank_read_enable, bank_write_enable}), 32'h0);
    cyc();
    idle();
    reset = 1'b0;

    // 1: core0 write then read of 0x10
    rq(0, 1'b1, 8'h10, 8'hA5);
    @(negedge clk); chk("t1_ready_w", 32'(req_ready), 32'h1);
    cyc(); idle(); rq(0, 1'b0, 8'h10, 8'h00);
    @(negedge clk); chk("t1_ready_r", 32'(req_ready), 32'h1);
    chk("t1_bank_wr", 32'({bank_write_enable, bank_addr, bank_data_in}), 32'h110A5);
    cyc(); idle();
    @(negedge clk); chk("t1_wack_v", 32'(rsp_valid), 32'h1); chk("t1_wack_d", 32'(rsp_data), 32'h0);
    cyc();
    @(negedge clk); chk("t1_rd_v", 32'(rsp_valid), 32'h1); chk("t1_rd_d", 32'(rsp_data), 32'hA5);
    cyc();

    // 2: all four cores from reset, reading 0x10
    do_reset();
    for (int k = 0; k < 10; k++) begin
      idle();
      if (k < 8) for (int i = 0; i < N; i++) rq(i, 1'b0, 8'h10, 8'h00);
      @(negedge clk);
      if (k < 8) chk("t2_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk("t2_rsp_v", 32'(rsp_valid), 32'(1 << ((k - 2) % 4)));
        chk("t2_rsp_d", 32'(rsp_data), 32'hA5);
      end
      cyc();
    end

    // 3: rr_ptr=2 with cores 1,3 requesting
    do_reset();
    rq(1, 1'b0, 8'h10, 8'h00);
    cyc(); idle();
    rq(1, 1'b0, 8'h10, 8'h00); rq(3, 1'b0, 8'h10, 8'h00);
    @(negedge clk); chk("t3_first", 32'(req_ready), 32'h8);
    cyc(); idle(); rq(1, 1'b0, 8'h10, 8'h00);
    @(negedge clk); chk("t3_second", 32'(req_ready), 32'h2);
    cyc(); idle(); cyc(); cyc();

    // 4: write 0x20 from core2, read it back from core0 next cycle
    rq(2, 1'b1, 8'h20, 8'h5A);
    @(negedge clk); chk("t4_ready_w", 32'(req_ready), 32'h4);
    cyc(); idle(); rq(0, 1'b0, 8'h20, 8'h00);
    @(negedge clk); chk("t4_ready_r", 32'(req_ready), 32'h1);
    cyc(); idle();
    @(negedge clk); chk("t4_wack_v", 32'(rsp_valid), 32'h4); chk("t4_wack_d", 32'(rsp_data), 32'h0);
    cyc();
    @(negedge clk); chk("t4_raw_v", 32'(rsp_valid), 32'h1); chk("t4_raw_d", 32'(rsp_data), 32'h5A);
    cyc();

    // 5: reset lands with two reads in flight (rr_ptr is 1 here)
    rq(1, 1'b0, 8'h10, 8'h00); rq(2, 1'b0, 8'h20, 8'h00);
    cyc(); idle(); rq(2, 1'b0, 8'h20, 8'h00);
    cyc(); idle();
    reset = 1'b1;
    rq(0, 1'b0, 8'h10, 8'h00); rq(1, 1'b0, 8'h10, 8'h00); rq(3, 1'b0, 8'h10, 8'h00);
    @(negedge clk); chk("t5_rst_ready", 32'(req_ready), 32'h0); chk("t5_rst_rsp", 32'(rsp_valid), 32'h0);
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("t5_ptr0", 32'(req_ready), 32'h1);
    chk("t5_no_rsp", 32'(rsp_valid), 32'h0);
    chk("t5_bank0", 32'({bank_addr, bank_data_in, bank_read_enable, bank_write_enable}), 32'h0);
    cyc(); idle();
    @(negedge clk); chk("t5_no_rsp2", 32'(rsp_valid), 32'h0);
    cyc(); cyc(); cyc();

`ifdef BANK_ARB_STALL_CNT_EN
    // 6: core2 blocked by 3, 0, 1 in turn
    do_reset();
    @(negedge clk); chk("t6_clr", 32'(stall_cnt[31:0]), 32'h0);
    rq(2, 1'b0, 8'h10, 8'h00);
    cyc(); idle();
    for (int i = 0; i < N; i++) rq(i, 1'b0, 8'h10, 8'h00);
    cyc(); req_valid[3] = 1'b0;
    cyc(); req_valid[0] = 1'b0;
    cyc(); req_valid[1] = 1'b0;
    cyc(); idle();
    @(negedge clk);
    chk("t6_cnt0", 32'(stall_cnt[0 +: 16]), 32'd1);
    chk("t6_cnt1", 32'(stall_cnt[16 +: 16]), 32'd2);
    chk("t6_cnt2", 32'(stall_cnt[32 +: 16]), 32'd3);
    chk("t6_cnt3", 32'(stall_cnt[48 +: 16]), 32'd0);
    cyc(); cyc();
    do_reset();
    @(negedge clk); chk("t6_rst", 32'(stall_cnt[32 +: 16]), 32'd0);
    cyc();
`endif

    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
